demux_1to4_buf: RTL and testbench



---
 rtl/demux_1to4_buf.sv | 142 ++++++++++++++
 tb/tb_demux_1to4_buf.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_buf.sv
// 1-to-4 demultiplexer with a DEPTH-entry FIFO and valid/ready handshake per output channel.
// Defining DEMUX_BROADCAST_EN adds in_bcast: one accepted word is pushed into all four FIFOs.
module demux_1to4_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
`ifdef DEMUX_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem  [4][DEPTH];
  logic [PW-1:0]    r_wptr [4];
  logic [PW-1:0]    r_rptr [4];
  logic [CW-1:0]    r_cnt  [4];
  logic [WIDTH-1:0] r_head [4];
  logic [3:0]       r_valid;

  logic [3:0]       w_full;
  logic [3:0]       w_dest;
  logic [3:0]       w_push;
  logic [3:0]       w_pop;
  logic [3:0]       w_out_ready;
  logic             w_bcast;
  logic [PW-1:0]    w_wptr_nxt [4];
  logic [PW-1:0]    w_rptr_nxt [4];
  logic [CW-1:0]    w_cnt_nxt  [4];
  logic [WIDTH-1:0] w_head_nxt [4];

`ifdef DEMUX_BROADCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_out_ready = {out_ready3, out_ready2, out_ready1, out_ready0};

  // Full flags come straight from the registered counts.
  always_comb begin
    w_full = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      w_full[c] = (r_cnt[c] == CW'(DEPTH));
    end
  end

  // Destination decode and acceptance; in_ready never looks at in_valid or any pop.
  always_comb begin
    w_dest   = 4'b0000;
    in_ready = 1'b0;
    case (in_sel)
      2'd0:    w_dest = 4'b0001;
      2'd1:    w_dest = 4'b0010;
      2'd2:    w_dest = 4'b0100;
      2'd3:    w_dest = 4'b1000;
      default: w_dest = 4'b0000;
    endcase
    if (w_bcast) begin
      w_dest   = 4'b1111;
      in_ready = ~|w_full;
    end else begin
      in_ready = ~w_full[in_sel];
    end
  end

  // Per-channel next state, including the head word the output register will hold.
  always_comb begin
    w_push = 4'b0000;
    w_pop  = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      w_push[c]     = in_valid & in_ready & w_dest[c];
      w_pop[c]      = r_valid[c] & w_out_ready[c];
      w_wptr_nxt[c] = w_push[c] ? (r_wptr[c] + PW'(1)) : r_wptr[c];
      w_rptr_nxt[c] = w_pop[c]  ? (r_rptr[c] + PW'(1)) : r_rptr[c];
      w_cnt_nxt[c]  = r_cnt[c] + CW'(w_push[c]) - CW'(w_pop[c]);
      // The slot being written this cycle is not in r_mem yet, so take it from in_data.
      if (w_cnt_nxt[c] == {CW{1'b0}}) begin
        w_head_nxt[c] = {WIDTH{1'b0}};
      end else if (w_push[c] && (w_rptr_nxt[c] == r_wptr[c])) begin
        w_head_nxt[c] = in_data;
      end else begin
        w_head_nxt[c] = r_mem[c][w_rptr_nxt[c]];
      end
    end
  end

  // FIFO storage, pointers, counts and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[c][d] <= {WIDTH{1'b0}};
        end
        r_wptr[c] <= {PW{1'b0}};
        r_rptr[c] <= {PW{1'b0}};
        r_cnt[c]  <= {CW{1'b0}};
        r_head[c] <= {WIDTH{1'b0}};
      end
      r_valid <= 4'b0000;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wptr[c]] <= in_data;
        end
        r_wptr[c]  <= w_wptr_nxt[c];
        r_rptr[c]  <= w_rptr_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
        r_head[c]  <= w_head_nxt[c];
        r_valid[c] <= (w_cnt_nxt[c] != {CW{1'b0}});
      end
    end
  end

  assign out_data0  = r_head[0];
  assign out_data1  = r_head[1];
  assign out_data2  = r_head[2];
  assign out_data3  = r_head[3];
  assign out_valid0 = r_valid[0];
  assign out_valid1 = r_valid[1];
  assign out_valid2 = r_valid[2];
  assign out_valid3 = r_valid[3];

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Scoreboard bench for demux_1to4_buf: per-channel expected queues filled on accepted pushes
// and drained on pops; broadcast scenario compiled in with DEMUX_BROADCAST_EN.
module tb_demux_1to4_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_bcast;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic             out_valid0, out_valid1, out_valid2, out_valid3;
  logic [3:0]       ordy;

  logic [WIDTH-1:0] od [4];
  logic [3:0]       ov;
  logic [WIDTH-1:0] sb [4][$];
  int               n_checks = 0;
  int               n_pass   = 0;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign ov    = {out_valid3, out_valid2, out_valid1, out_valid0};

  demux_1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast   (in_bcast),
`endif
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_valid3 (out_valid3),
    .out_ready0 (ordy[0]),
    .out_ready1 (ordy[1]),
    .out_ready2 (ordy[2]),
    .out_ready3 (ordy[3])
  );

  always #5 clock = ~clock;

  // Advance the reference model by one edge using the inputs currently applied.
  task automatic tick();
    logic acc;
    if (reset) begin
      for (int c = 0; c < 4; c++) sb[c].delete();
    end else begin
      acc = 1'b1;
      if (in_bcast) begin
        for (int c = 0; c < 4; c++) if (sb[c].size() >= DEPTH) acc = 1'b0;
      end else begin
        acc = (sb[in_sel].size() < DEPTH);
      end
      for (int c = 0; c < 4; c++) if (ordy[c] && sb[c].size() != 0) void'(sb[c].pop_front());
      if (in_valid && acc) begin
        if (in_bcast) begin
          for (int c = 0; c < 4; c++) sb[c].push_back(in_data);
        end else begin
          sb[in_sel].push_back(in_data);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic             ev;
    logic [WIDTH-1:0] ed;
    reset = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = 2'd0;
    in_data = 32'h0; ordy = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      ev = 1'b0; ed = 32'h0;
      n_checks++;
      if (ov[c] !== ev || od[c] !== ed)
        $display("FAIL reset_out ch%0d: got v=%b d=%h, want v=%b d=%h", c, ov[c], od[c], ev, ed);
      else n_pass++;
      in_sel = 2'(c);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready sel%0d: got %b, want 1", c, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic             ev;
    logic [WIDTH-1:0] ed;
    in_sel = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1; ordy = 4'b0000;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL single_ready_pre: got %b, want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 32'hDEADBEEF)
      $display("FAIL single_out2: got v=%b d=%h, want v=1 d=deadbeef", out_valid2, out_data2);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL single_ready_post: got %b, want 1", in_ready);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      ev = (sb[c].size() != 0); ed = ev ? sb[c][0] : 32'h0;
      n_checks++;
      if (ov[c] !== ev || od[c] !== ed)
        $display("FAIL single_sb ch%0d: got v=%b d=%h, want v=%b d=%h", c, ov[c], od[c], ev, ed);
      else n_pass++;
    end
    ordy[2] = 1'b1;
    tick();
    ordy[2] = 1'b0;
    n_checks++;
    if (out_valid2 !== 1'b0 || out_data2 !== 32'h0)
      $display("FAIL single_drain: got v=%b d=%h, want v=0 d=0", out_valid2, out_data2);
    else n_pass++;
  endtask

  task automatic test_full();
    logic             ev;
    logic [WIDTH-1:0] ed;
    in_sel = 2'd0; in_valid = 1'b1; ordy = 4'b0000;
    in_data = 32'h1; tick();
    in_data = 32'h2; tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL full_ready_sel0: got %b, want 0", in_ready);
    else n_pass++;
    in_sel = 2'd1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL full_ready_sel1: got %b, want 1", in_ready);
    else n_pass++;
    // Full channel popping this cycle still refuses the push.
    in_sel = 2'd0; in_valid = 1'b1; in_data = 32'h3; ordy[0] = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL full_ready_popping: got %b, want 0", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 32'h2)
      $display("FAIL full_order2: got v=%b d=%h, want v=1 d=00000002", out_valid0, out_data0);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    ordy[0] = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 32'h3)
      $display("FAIL full_order3: got v=%b d=%h, want v=1 d=00000003", out_valid0, out_data0);
    else n_pass++;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ev = (sb[c].size() != 0); ed = ev ? sb[c][0] : 32'h0;
      n_checks++;
      if (ov[c] !== ev || od[c] !== ed)
        $display("FAIL full_sb ch%0d: got v=%b d=%h, want v=%b d=%h", c, ov[c], od[c], ev, ed);
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    ordy = 4'b1000; in_sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h10 + 32'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready i%0d: got %b, want 1", i, in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid3 !== 1'b1 || out_data3 !== 32'h10 + 32'(i) || sb[3].size() != 1 || sb[3][0] !== out_data3)
        $display("FAIL stream_out i%0d: got v=%b d=%h, want v=1 d=%h", i, out_valid3, out_data3, 32'h10 + 32'(i));
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    ordy = 4'b0000;
    n_checks++;
    if (out_valid3 !== 1'b0 || out_data3 !== 32'h0)
      $display("FAIL stream_drain: got v=%b d=%h, want v=0 d=0", out_valid3, out_data3);
    else n_pass++;
  endtask

  task automatic test_interleave();
    logic             ev, er;
    logic [WIDTH-1:0] ed;
    ordy = 4'b0100; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_sel  = (i % 2 == 0) ? 2'd1 : 2'd2;
      in_data = ((i % 2 == 0) ? 32'hA0 : 32'hB0) + 32'(i / 2);
      #1;
      er = (sb[in_sel].size() < DEPTH);
      n_checks++;
      if (in_ready !== er) $display("FAIL inter_ready i%0d sel%0d: got %b, want %b", i, in_sel, in_ready, er);
      else n_pass++;
      tick();
      for (int c = 1; c < 3; c++) begin
        ev = (sb[c].size() != 0); ed = ev ? sb[c][0] : 32'h0;
        n_checks++;
        if (ov[c] !== ev || od[c] !== ed)
          $display("FAIL inter_sb i%0d ch%0d: got v=%b d=%h, want v=%b d=%h", i, c, ov[c], od[c], ev, ed);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_data1 !== 32'hA0) $display("FAIL inter_ch1_head: got %h, want 000000a0", out_data1);
    else n_pass++;
    ordy = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      ev = (sb[1].size() != 0); ed = ev ? sb[1][0] : 32'h0;
      n_checks++;
      if (out_valid1 !== ev || out_data1 !== ed)
        $display("FAIL inter_drain1 i%0d: got v=%b d=%h, want v=%b d=%h", i, out_valid1, out_data1, ev, ed);
      else n_pass++;
    end
    ordy = 4'b0000;
  endtask

  task automatic test_reset_mid();
    ordy = 4'b0000; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 32'hC0; tick(); in_data = 32'hC1; tick();
    in_sel = 2'd3; in_data = 32'hD0; tick(); in_data = 32'hD1; tick();
    n_checks++;
    if (ov !== 4'b1001) $display("FAIL rmid_filled: got valid=%b, want 1001", ov);
    else n_pass++;
    reset = 1'b1; in_sel = 2'd1; in_data = 32'h77; ordy = 4'b1111;
    tick();
    reset = 1'b0; in_valid = 1'b0; ordy = 4'b0000;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (ov[c] !== 1'b0 || od[c] !== 32'h0)
        $display("FAIL rmid_clear ch%0d: got v=%b d=%h, want v=0 d=0", c, ov[c], od[c]);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (out_valid1 !== 1'b0 || sb[1].size() != 0)
      $display("FAIL rmid_not_stored: got v=%b, want 0", out_valid1);
    else n_pass++;
  endtask

`ifdef DEMUX_BROADCAST_EN
  task automatic test_broadcast();
    ordy = 4'b0000; in_valid = 1'b1; in_sel = 2'd1;
    in_data = 32'hE0; tick(); in_data = 32'hE1; tick();
    in_bcast = 1'b1; in_sel = 2'd0; in_data = 32'h5A5A5A5A;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bcast_blocked: got %b, want 0", in_ready);
    else n_pass++;
    ordy[1] = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bcast_open: got %b, want 1", in_ready);
    else n_pass++;
    tick();
    in_bcast = 1'b0; in_valid = 1'b0; ordy = 4'b0000;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (ov[c] !== 1'b1 || od[c] !== 32'h5A5A5A5A || sb[c].size() != 1)
        $display("FAIL bcast_out ch%0d: got v=%b d=%h, want v=1 d=5a5a5a5a", c, ov[c], od[c]);
      else n_pass++;
    end
    ordy = 4'b1111;
    tick();
    ordy = 4'b0000;
    n_checks++;
    if (ov !== 4'b0000) $display("FAIL bcast_drain: got valid=%b, want 0000", ov);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_interleave();
    test_reset_mid();
`ifdef DEMUX_BROADCAST_EN
    test_broadcast();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
